// File: rtl/fc_layer_engine.sv
// Fully-connected classifier stage: streams bias, inputs and weights over a single-port
// memory handshake, accumulates Q8.8 dot products, writes results and tracks the arg-max.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; bases latched on accept
// S_LD_BIAS | read b[o]; acc seeded with bias aligned to product scale
// S_LD_X    | read x[i] into x_q
// S_LD_W    | read w[o][i]; acc += x*w; loop to S_LD_X until last input
// S_WRITE   | write saturated (optionally rectified) y[o]; update arg-max
// S_DONE    | one-cycle done pulse; class outputs already hold the winner
module fc_layer_engine #(
   parameter int N_IN   = 120,
   parameter int N_OUT  = 10,
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int ADDR_W = 16,
   parameter int RELU   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        in_base,
   input  logic [ADDR_W-1:0]        w_base,
   input  logic [ADDR_W-1:0]        b_base,
   input  logic [ADDR_W-1:0]        out_base,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               class_idx,
   output logic [DATA_W-1:0]        class_score
);

   localparam int ACC_W  = 40;
   localparam int PROD_W = 2 * DATA_W;
   localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int OW     = 8;

   localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_BIAS,
      S_LD_X,
      S_LD_W,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [ADDR_W-1:0]        in_base_q;
   logic [ADDR_W-1:0]        b_base_q;
   logic [ADDR_W-1:0]        out_base_q;
   logic [ADDR_W-1:0]        w_ptr;
   logic [IW-1:0]            i_cnt;
   logic [OW-1:0]            o_cnt;
   logic signed [DATA_W-1:0] x_q;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] best_score;
   logic [7:0]               best_idx;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_shr;
   logic signed [DATA_W-1:0] y_sat;
   logic signed [DATA_W-1:0] y_out;
   logic                     last_i;
   logic                     last_o;
   logic                     y_better;

   // Products are exact in 32 bits; 40-bit accumulation leaves headroom for N_IN terms.
   assign prod     = PROD_W'(x_q) * PROD_W'($signed(mem_rdata));
   assign bias_ext = ACC_W'($signed(mem_rdata)) <<< FRAC;
   assign acc_shr  = acc >>> FRAC;

   always_comb begin
      y_sat = acc_shr[DATA_W-1:0];
      if (acc_shr > Y_MAX)
         y_sat = Y_MAX[DATA_W-1:0];
      else if (acc_shr < Y_MIN)
         y_sat = Y_MIN[DATA_W-1:0];
   end

   assign y_out    = ((RELU != 0) && (y_sat < 0)) ? '0 : y_sat;
   assign y_better = (y_out > best_score);
   assign last_i   = (i_cnt == IW'(N_IN - 1));
   assign last_o   = (o_cnt == OW'(N_OUT - 1));

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nx = S_LD_BIAS;
         end
         S_LD_BIAS: begin
            mem_req  = 1'b1;
            mem_addr = b_base_q + ADDR_W'(o_cnt);
            if (mem_ack)
               state_nx = S_LD_X;
         end
         S_LD_X: begin
            mem_req  = 1'b1;
            mem_addr = in_base_q + ADDR_W'(i_cnt);
            if (mem_ack)
               state_nx = S_LD_W;
         end
         S_LD_W: begin
            mem_req  = 1'b1;
            mem_addr = w_ptr;
            if (mem_ack)
               state_nx = last_i ? S_WRITE : S_LD_X;
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = out_base_q + ADDR_W'(o_cnt);
            mem_wdata = y_out;
            if (mem_ack)
               state_nx = last_o ? S_DONE : S_LD_BIAS;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Weight rows are contiguous and visited in order, so a single running pointer
   // replaces the o*N_IN+i address arithmetic.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_base_q   <= '0;
         b_base_q    <= '0;
         out_base_q  <= '0;
         w_ptr       <= '0;
         i_cnt       <= '0;
         o_cnt       <= '0;
         x_q         <= '0;
         acc         <= '0;
         best_score  <= '0;
         best_idx    <= '0;
         class_idx   <= '0;
         class_score <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  in_base_q  <= in_base;
                  b_base_q   <= b_base;
                  out_base_q <= out_base;
                  w_ptr      <= w_base;
                  i_cnt      <= '0;
                  o_cnt      <= '0;
                  acc        <= '0;
                  best_score <= Y_MIN[DATA_W-1:0];
                  best_idx   <= '0;
               end
            end
            S_LD_BIAS: begin
               if (mem_ack) begin
                  acc   <= bias_ext;
                  i_cnt <= '0;
               end
            end
            S_LD_X: begin
               if (mem_ack)
                  x_q <= $signed(mem_rdata);
            end
            S_LD_W: begin
               if (mem_ack) begin
                  acc   <= acc + ACC_W'(prod);
                  w_ptr <= w_ptr + ADDR_W'(1);
                  if (!last_i)
                     i_cnt <= i_cnt + IW'(1);
               end
            end
            S_WRITE: begin
               if (mem_ack) begin
                  if (y_better) begin
                     best_score <= y_out;
                     best_idx   <= o_cnt;
                  end
                  // Publish the winner on the last write so it is valid alongside done.
                  if (last_o) begin
                     class_idx   <= y_better ? o_cnt : best_idx;
                     class_score <= y_better ? y_out : best_score;
                  end else begin
                     o_cnt <= o_cnt + OW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine (N_IN=4, N_OUT=3) with a stalling RAM model
// and a plain-arithmetic reference of the fully-connected layer.
module tb_fc_layer_engine;

   localparam int N_IN  = 4;
   localparam int N_OUT = 3;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int LAT   = N_OUT * (2 * N_IN + 2) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          start0 = 1'b0, start1 = 1'b0;
   logic          sel = 1'b0;
   logic [AW-1:0] in_base = '0, w_base = '0, b_base = '0, out_base = '0;

   logic          req0, we0, busy0, done0, req1, we1, busy1, done1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1, score0, score1;
   logic [7:0]    idx0, idx1;
   logic          ack0, ack1, ack_raw;
   logic [DW-1:0] rdata;

   logic          d_req, d_we, d_busy, d_done, d_ack;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_score;
   logic [7:0]    d_idx;

   logic [DW-1:0] ram    [256];
   logic [DW-1:0] wr_ram [256];
   int            wr_count = 0;
   logic          clr_wr = 1'b0;
   int            wait_cnt = 0;
   int            max_stall = 0;
   int            stall_total = 0;

   logic signed [DW-1:0] xv [N_IN];
   logic signed [DW-1:0] wv [N_OUT*N_IN];
   logic signed [DW-1:0] bv [N_OUT];
   logic [DW-1:0]        exp_y [N_OUT];
   logic [7:0]           exp_idx;
   logic [DW-1:0]        exp_score;

   int n_cmp = 0;
   int n_fail = 0;

   fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .FRAC(8), .ADDR_W(AW), .RELU(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0),
      .in_base(in_base), .w_base(w_base), .b_base(b_base), .out_base(out_base),
      .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
      .mem_rdata(rdata), .mem_ack(ack0),
      .busy(busy0), .done(done0), .class_idx(idx0), .class_score(score0));

   fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .FRAC(8), .ADDR_W(AW), .RELU(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .in_base(in_base), .w_base(w_base), .b_base(b_base), .out_base(out_base),
      .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
      .mem_rdata(rdata), .mem_ack(ack1),
      .busy(busy1), .done(done1), .class_idx(idx1), .class_score(score1));

   assign d_req   = sel ? req1   : req0;
   assign d_we    = sel ? we1    : we0;
   assign d_addr  = sel ? addr1  : addr0;
   assign d_wdata = sel ? wdata1 : wdata0;
   assign d_busy  = sel ? busy1  : busy0;
   assign d_done  = sel ? done1  : done0;
   assign d_idx   = sel ? idx1   : idx0;
   assign d_score = sel ? score1 : score0;
   assign d_ack   = sel ? ack1   : ack0;

   // Ack is also raised with no request pending; the DUT must ignore it then.
   assign ack_raw = (wait_cnt == 0);
   assign ack0    = !sel && ack_raw;
   assign ack1    = sel && ack_raw;
   assign rdata   = ram[d_addr[7:0]];

   always @(posedge clk) begin
      if (clr_wr) begin
         for (int k = 0; k < 256; k++) wr_ram[k] <= 16'hDEAD;
         wr_count <= 0;
      end else if (d_req) begin
         if (wait_cnt == 0) begin
            if (d_we) begin
               wr_ram[d_addr[7:0]] <= d_wdata;
               wr_count <= wr_count + 1;
            end
            wait_cnt <= (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
         end else begin
            wait_cnt    <= wait_cnt - 1;
            stall_total <= stall_total + 1;
         end
      end
   end

   task automatic model(input bit relu);
      longint acc, y, best;
      best = -32768;
      exp_idx = 8'd0;
      for (int o = 0; o < N_OUT; o++) begin
         acc = longint'(bv[o]) * 256;
         for (int i = 0; i < N_IN; i++) acc += longint'(xv[i]) * longint'(wv[o*N_IN+i]);
         y = acc >>> 8;
         if (y > 32767) y = 32767;
         if (y < -32768) y = -32768;
         if (relu && y < 0) y = 0;
         exp_y[o] = y[15:0];
         if (y > best) begin
            best = y;
            exp_idx = 8'(o);
         end
      end
      exp_score = best[15:0];
   endtask

   task automatic set_basic();
      xv = '{16'sh0100, 16'sh0200, 16'shFF00, 16'sh0080};
      wv = '{16'sh0100, 16'sh0100, 16'sh0100, 16'sh0100,
             16'sh0000, 16'sh0000, 16'shFF00, 16'sh0000,
             16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000};
      bv = '{16'sh0000, 16'sh0040, 16'shFF00};
      in_base = 16'h0004; w_base = 16'h0024; b_base = 16'h0044; out_base = 16'h0064;
   endtask

   function automatic logic [15:0] rnd16();
      if ($urandom_range(3, 0) == 0) return 16'($urandom);
      return 16'($urandom_range(1536, 0)) - 16'd768;
   endfunction

   task automatic load_mem();
      for (int i = 0; i < N_IN; i++) ram[int'(in_base) + i] = xv[i];
      for (int k = 0; k < N_OUT*N_IN; k++) ram[int'(w_base) + k] = wv[k];
      for (int o = 0; o < N_OUT; o++) ram[int'(b_base) + o] = bv[o];
   endtask

   task automatic clear_wr();
      @(negedge clk); clr_wr = 1'b1;
      @(negedge clk); clr_wr = 1'b0;
   endtask

   // Starts the selected DUT and records what happened; comparisons live in the callers.
   task automatic run_cur(output int cycles, output int stalls, output int stab_err,
                          output bit busy_gap, output int done_cnt, output bit busy_after,
                          output bit timeout);
      int s0;
      bit pst;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      logic pw;
      cycles = 0; stab_err = 0; busy_gap = 0; done_cnt = 0; timeout = 0;
      pst = 0; pa = '0; pd = '0; pw = 0;
      @(negedge clk);
      s0 = stall_total;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      while (1) begin
         @(posedge clk); #1;
         start0 = 1'b0; start1 = 1'b0;
         cycles++;
         if (pst && d_req && (d_addr !== pa || d_wdata !== pd || d_we !== pw)) stab_err++;
         pst = d_req && !d_ack; pa = d_addr; pd = d_wdata; pw = d_we;
         if (d_busy !== 1'b1) busy_gap = 1;
         if (d_done === 1'b1) begin done_cnt++; break; end
         if (cycles > 4000) begin timeout = 1; break; end
      end
      stalls = stall_total - s0;
      @(posedge clk); #1;
      if (d_done === 1'b1) done_cnt++;
      busy_after = d_busy;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (req0 !== 1'b0 || we0 !== 1'b0) begin n_fail++; $display("FAIL reset_req0: req=%b we=%b required 0 0", req0, we0); end
      n_cmp++; if (addr0 !== 16'h0 || wdata0 !== 16'h0) begin n_fail++; $display("FAIL reset_bus0: addr=%h wdata=%h required 0", addr0, wdata0); end
      n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL reset_status0: busy=%b done=%b required 0 0", busy0, done0); end
      n_cmp++; if (idx0 !== 8'h0 || score0 !== 16'h0) begin n_fail++; $display("FAIL reset_class0: idx=%h score=%h required 0", idx0, score0); end
      n_cmp++; if (req1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || idx1 !== 8'h0 || score1 !== 16'h0) begin
         n_fail++; $display("FAIL reset_dut1: req=%b busy=%b done=%b idx=%h score=%h required all 0", req1, busy1, done1, idx1, score1); end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (busy0 !== 1'b0 || req0 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b req=%b required 0 0", busy0, req0); end
   endtask

   task automatic check_run(input string name, input logic [DW-1:0] ey [N_OUT], input logic [7:0] eidx,
                            input logic [DW-1:0] escore, input int max_st);
      int cyc, st, se, dc; bit bg, ba, to;
      load_mem(); clear_wr();
      max_stall = max_st;
      run_cur(cyc, st, se, bg, dc, ba, to);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no done within budget", name); end
      n_cmp++; if (cyc !== LAT + st) begin n_fail++; $display("FAIL %s_latency: done after %0d cycles required %0d (stalls %0d)", name, cyc, LAT + st, st); end
      for (int o = 0; o < N_OUT; o++) begin
         n_cmp++; if (wr_ram[int'(out_base) + o] !== ey[o]) begin n_fail++;
            $display("FAIL %s_y%0d: got %h required %h", name, o, wr_ram[int'(out_base) + o], ey[o]); end
      end
      n_cmp++; if (wr_count !== N_OUT) begin n_fail++; $display("FAIL %s_writes: %0d writes required %0d", name, wr_count, N_OUT); end
      n_cmp++; if (d_idx !== eidx || d_score !== escore) begin n_fail++;
         $display("FAIL %s_argmax: idx=%0d score=%h required idx=%0d score=%h", name, d_idx, d_score, eidx, escore); end
      n_cmp++; if (bg !== 1'b0 || ba !== 1'b0) begin n_fail++; $display("FAIL %s_busy: gap=%b after_done=%b required 0 0", name, bg, ba); end
      n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL %s_done_pulses: %0d required 1", name, dc); end
      n_cmp++; if (se !== 0) begin n_fail++; $display("FAIL %s_stall_stability: %0d bus changes during stalls required 0", name, se); end
   endtask

   task automatic test_basic();
      logic [DW-1:0] ey [N_OUT];
      sel = 1'b0; set_basic();
      ey = '{16'h0280, 16'h0140, 16'hFF00};
      check_run("basic", ey, 8'd0, 16'h0280, 0);
   endtask

   task automatic test_saturation();
      logic [DW-1:0] ey [N_OUT];
      sel = 1'b0; set_basic();
      foreach (xv[i]) xv[i] = 16'sh7F00;
      foreach (wv[k]) wv[k] = 16'sh7F00;
      foreach (bv[o]) bv[o] = 16'sh7F00;
      ey = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
      check_run("sat_pos", ey, 8'd0, 16'h7FFF, 0);
      foreach (wv[k]) wv[k] = 16'sh8100;
      foreach (bv[o]) bv[o] = 16'sh0000;
      ey = '{16'h8000, 16'h8000, 16'h8000};
      check_run("sat_neg", ey, 8'd0, 16'h8000, 0);
   endtask

   task automatic test_relu();
      logic [DW-1:0] ey [N_OUT];
      sel = 1'b1; set_basic();
      ey = '{16'h0280, 16'h0140, 16'h0000};
      check_run("relu", ey, 8'd0, 16'h0280, 0);
      sel = 1'b0;
   endtask

   task automatic test_tie();
      logic [DW-1:0] ey [N_OUT];
      sel = 1'b0; set_basic();
      foreach (xv[i]) xv[i] = rnd16();
      foreach (wv[k]) wv[k] = 16'sh0000;
      bv = '{16'sh0080, 16'sh0100, 16'sh0100};
      ey = '{16'h0080, 16'h0100, 16'h0100};
      check_run("tie", ey, 8'd1, 16'h0100, 0);
   endtask

   task automatic test_stalls();
      logic [DW-1:0] ey [N_OUT];
      sel = 1'b0; set_basic();
      ey = '{16'h0280, 16'h0140, 16'hFF00};
      for (int r = 0; r < 2; r++) check_run("stall", ey, 8'd0, 16'h0280, 5);
      max_stall = 0;
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         sel = r[0];
         in_base  = 16'h0000 + 16'($urandom_range(15, 0));
         w_base   = 16'h0020 + 16'($urandom_range(15, 0));
         b_base   = 16'h0040 + 16'($urandom_range(15, 0));
         out_base = 16'h0060 + 16'($urandom_range(15, 0));
         foreach (xv[i]) xv[i] = rnd16();
         foreach (wv[k]) wv[k] = rnd16();
         foreach (bv[o]) bv[o] = rnd16();
         model(sel);
         check_run("random", exp_y, exp_idx, exp_score, int'($urandom_range(3, 0)));
      end
      sel = 1'b0; max_stall = 0;
   endtask

   task automatic test_reset_midrun();
      logic [DW-1:0] ey [N_OUT];
      int cyc; bit found;
      sel = 1'b0; set_basic(); load_mem(); clear_wr();
      ey = '{16'h0280, 16'h0140, 16'hFF00};
      cyc = 0; found = 0;
      @(negedge clk); start0 = 1'b1;
      while (cyc < 200) begin
         @(posedge clk); #1;
         start0 = 1'b0; cyc++;
         if (d_req && !d_we && d_addr >= w_base + 16'(N_IN) && d_addr < w_base + 16'(2*N_IN)) begin
            found = 1; break;
         end
      end
      n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL midrun_reach_ld_w: o=1 weight read not seen"); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (d_req !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0) begin n_fail++;
         $display("FAIL midrun_reset_status: req=%b busy=%b done=%b required 0 0 0", d_req, d_busy, d_done); end
      n_cmp++; if (d_idx !== 8'h0 || d_score !== 16'h0) begin n_fail++;
         $display("FAIL midrun_reset_class: idx=%h score=%h required 0 0", d_idx, d_score); end
      check_run("after_reset", ey, 8'd0, 16'h0280, 0);
   endtask

   task automatic test_back_to_back();
      int first_done, second_done, dc;
      sel = 1'b0; set_basic(); load_mem(); clear_wr();
      first_done = 0; second_done = 0; dc = 0;
      @(negedge clk); start0 = 1'b1;
      for (int c = 1; c <= 3 * LAT; c++) begin
         @(posedge clk); #1;
         if (c == 1) start0 = 1'b0;
         if (c == 10) start0 = 1'b1;
         if (d_done === 1'b1) begin
            dc++;
            if (first_done == 0) first_done = c; else second_done = c;
         end
         if (first_done != 0 && c == first_done + 1) begin
            n_cmp++; if (d_busy !== 1'b0 || d_done !== 1'b0) begin n_fail++;
               $display("FAIL b2b_idle_gap: busy=%b done=%b required 0 0", d_busy, d_done); end
         end
         if (first_done != 0 && c == first_done + 2) begin
            start0 = 1'b0;
            n_cmp++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: busy=%b required 1", d_busy); end
         end
         if (second_done != 0) break;
      end
      n_cmp++; if (first_done !== LAT) begin n_fail++; $display("FAIL b2b_first_done: at %0d required %0d", first_done, LAT); end
      n_cmp++; if (second_done !== LAT + 1 + LAT) begin n_fail++; $display("FAIL b2b_second_done: at %0d required %0d", second_done, 2 * LAT + 1); end
      n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL b2b_done_count: %0d required 2", dc); end
      n_cmp++; if (wr_ram[int'(out_base)] !== 16'h0280 || d_idx !== 8'd0 || d_score !== 16'h0280) begin n_fail++;
         $display("FAIL b2b_result: y0=%h idx=%0d score=%h required 0280 0 0280", wr_ram[int'(out_base)], d_idx, d_score); end
   endtask

   initial begin
      for (int k = 0; k < 256; k++) ram[k] = 16'h0;
      test_reset();
      test_basic();
      test_saturation();
      test_relu();
      test_stalls();
      test_random();
      test_tie();
      test_reset_midrun();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
- Fully-connected classifier stage directly downstream of the conv/pool layer loop in the CNN top level.
- Triggered once the final feature vector (120 values in LeNet) is in RAM.
- Reads inputs, weights and biases over a single-port memory handshake and computes N_OUT dot products in Q8.8 fixed point.
- Writes the results back to RAM and reports the arg-max class index and score.

Parameters:
- N_IN, 120, input vector length.
- N_OUT, 10, number of output neurons.
- DATA_W, 16, signed data width (Q8.8).
- FRAC, 8, fractional bits.
- ADDR_W, 16, memory address width.
- RELU, 0, 1 = clamp negative outputs to 0 before write/arg-max.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse or level; sampled only in IDLE.
- in_base  in  ADDR_W  address of x[0]; x[i] at in_base+i.
- w_base  in  ADDR_W  weight base; w[o][i] at w_base+o*N_IN+i (row-major).
- b_base  in  ADDR_W  bias base; b[o] at b_base+o.
- out_base  in  ADDR_W  result base; y[o] written to out_base+o.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  access complete (may be same cycle as req or later).
- busy  out  1  high from start accept until done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- class_idx  out  8  arg-max output index.
- class_score  out  DATA_W  arg-max output value.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; accumulator and counters cleared. Reset mid-operation aborts immediately; mem_req drops the next cycle. No partial result is retained.
- Base ports are latched on start accept. Later changes have no effect until the next start.
- FSM states:
  - IDLE: start=1 → LD_BIAS, busy=1, o=0; class_score = -32768 (internal best), class_idx=0.
  - LD_BIAS: read b_base+o. On ack: acc = sign_ext(b) << FRAC; i=0 → LD_X.
  - LD_X: read in_base+i. On ack: latch x → LD_W.
  - LD_W: read w_base+o*N_IN+i. On ack: acc += x*w (32-bit signed product, 40-bit signed acc). i==N_IN-1 → WRITE, else i++ → LD_X.
  - WRITE: y = saturate16(acc >>> FRAC) (arithmetic shift, floor; clamp to 0x7FFF / 0x8000); if RELU and y<0, y=0. Write y to out_base+o. On ack: if y > best (strict), best=y and idx=o. o==N_OUT-1 → DONE, else o++ → LD_BIAS.
  - DONE: done=1 for one cycle; class_idx/class_score updated from best; → IDLE; busy falls next cycle.
- Memory handshake:
  - mem_req, mem_we, mem_addr, mem_wdata stay stable while waiting for ack.
  - One access in flight at a time.
  - mem_req deasserts in IDLE and DONE; mem_ack outside a request is ignored.
- Latency: with mem_ack=1 continuously, done asserts exactly N_OUT*(2*N_IN+2)+1 cycles after the start-accept cycle. Each stall cycle (req without ack) adds exactly one cycle.
- start while busy is ignored. start held high in the done cycle does not re-trigger. It is re-sampled once the FSM is back in IDLE.
- Ties: lowest index wins.
- class_idx/class_score hold until the next DONE.

Test Plan:
- Basic (N_IN=4, N_OUT=3, ack tied high):
  - x=[0x0100,0x0200,0xFF00,0x0080].
  - w row0 all 0x0100, row1=[0,0,0xFF00,0], row2 all 0.
  - b=[0,0x0040,0xFF00].
  - Required: RAM y=[0x0280,0x0140,0xFF00], class_idx=0, class_score=0x0280, done exactly 31 cycles after start, busy high throughout.
- Saturation: x and w all 0x7F00, b=0x7F00 → y=0x7FFF for every output. x=0x7F00, w=0x8100 → y=0x8000.
- RELU=1 rerun of the basic case → y2 written as 0x0000. Tie case (two outputs both 0x0100 at o=1 and o=2) → class_idx=1.
- Random mem_ack stalls of 0–5 cycles per access:
  - Results and arg-max identical to the basic case.
  - mem_addr and mem_wdata stable across stalls.
  - done at 31 + total stall cycles.
- Reset asserted during LD_W of o=1 → next cycle: mem_req=0, busy=0, done=0, class_idx=0. A fresh start then yields the full basic-case result.
- start pulsed mid-run and held high through done → only one done pulse per accepted start. A second run begins only after the FSM returns to IDLE.
